fc_cpu_bus_master: RTL and testbench
====================================

// Module: fc_cpu_bus_master
// PURPOSE
//  Initiator for the FC cartridge CPU bus: turns a command stream (addr, rw, data) into
//  M2/ROMSEL/RW/address/data cycles that mapper targets latch on M2 falling edge.
//  Sits between the host-command logic and the cartridge edge.
//  Dumps PRG and programs mapper registers with no real 6502 present.
// PARAMETERS
//  DIV        14   osc50 cycles per M2 half-period (50 MHz/28 = 1.786 MHz M2)
//  HOLD_CYC   1    osc50 cycles address/data/rw held after M2 falls (>=1)
// PORTS
//  osc50         in   1   system clock, 50 MHz
//  rst_n         in   1   asynchronous reset, active low
//  cmd_valid     in   1   command present
//  cmd_ready     out  1   block accepts command this cycle
//  cmd_rw        in   1   1=read, 0=write
//  cmd_addr      in   16  CPU address; bit15 selects ROMSEL
//  cmd_wdata     in   8   write data
//  rsp_valid     out  1   one-cycle pulse: cycle finished (read and write)
//  rsp_rdata     out  8   sampled read data; valid with rsp_valid, held until next rsp
//  m2            out  1   CPU phi2 to cartridge
//  romsel        out  1   /ROMSEL, active low = ~(addr[15] & m2 phase)
//  cpu_rw        out  1   R/W to cartridge, 1=read
//  cpu_addr      out  15  A14..A0
//  cpu_data_out  out  8   data driven on writes
//  cpu_data_oe   out  1   1=drive cpu_data_out onto bus
//  cpu_data_in   in   8   bus data from cartridge
// BEHAVIOUR
//  Reset (async, rst_n=0): m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_out=0,
//   cpu_data_oe=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0; state=IDLE. Reset mid-cycle aborts
//   it with no rsp_valid; first cycle after release is IDLE with cmd_ready=1.
//  All bus outputs registered; no combinational path from cmd_* to bus pins.
//  FSM IDLE -> PHI1 -> PHI2 -> HOLD -> IDLE; phase counter 0..DIV-1 (or HOLD_CYC-1).
//   IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch cmd, go PHI1. cmd_ready=0 elsewhere.
//   PHI1 (DIV cycles): m2=0, romsel=1, cpu_addr/cpu_rw set; writes: cpu_data_oe=1.
//   PHI2 (DIV cycles): m2=1; romsel=0 iff addr[15]; cpu_rw/addr/data stable.
//    Reads: rsp_rdata <= cpu_data_in on the last PHI2 cycle (before m2 falls).
//   HOLD (HOLD_CYC cycles): m2=0; romsel stays as in PHI2 so a target sampling ~romsel at
//    M2 fall sees it; rw/addr/data held. On HOLD exit: romsel=1, cpu_data_oe=0,
//    cpu_rw=1, rsp_valid=1 for 1 cycle, state IDLE.
//  Latency accept->rsp_valid: 2*DIV+HOLD_CYC+1 osc50 cycles. Back-to-back: next accept one
//   cycle after rsp_valid; min cycle period 2*DIV+HOLD_CYC+1.
//  cmd_* ignored outside IDLE; command latched, not re-read mid-cycle.
//  cpu_data_oe never 1 while cpu_rw=1 (no bus contention).
//  addr[15]=0 cycles never assert romsel (RAM/register space $0000-$7FFF).
// CONFIGURATION
//  FC_BUS_IDLE_CLK_EN defined: M2 free-runs in IDLE with dummy reads (cpu_rw=1, addr
//   $0000, romsel=1, oe=0) so M2-counting mappers keep ticking. A command waits for the
//   current dummy cycle to end: accept latency 0..2*DIV+HOLD_CYC cycles. No rsp_valid for
//   dummies.
//  Not defined: M2 held 0 in IDLE; a command is accepted immediately.
// STRUCTURE
//  Package fc_bus_pkg: state enum (IDLE, PHI1, PHI2, HOLD), phase counter typedef
//   sized $clog2(DIV), ROMSEL_ACTIVE=1'b0, RW_READ=1'b1.
//  Sub-module fc_m2_phase_ctr: DIV counter with phase_done pulse, shared with a later PPU
//   master. FSM and bus registers stay in this module.
// TESTING (DIV=14, HOLD_CYC=1)
//  Write $8000<=$02 -> m2 high 14 cycles; romsel=0 those 14 and +1 HOLD; data $02 oe=1
//   through HOLD; rsp_valid 30 cycles after accept.
//  Read $6000, target drives $A5 -> romsel never 0, oe=0 throughout, rsp_rdata=$A5 on
//   rsp_valid.
//  Read $FFFC, data changes $11->$22 at 1st HOLD cycle -> rsp_rdata=$11.
//  Two queued commands (write $8000, read $8001) -> 2nd accept 1 cycle after 1st
//   rsp_valid, no m2 glitch between.
//  rst_n=0 mid-PHI2 of a write -> same cycle m2=0, romsel=1, oe=0, rw=1; no rsp_valid;
//   cmd_ready=1 first cycle after release.
//  FC_BUS_IDLE_CLK_EN: idle 200 cycles -> m2 period 29, romsel=1; command waits for
//   dummy end, then one real cycle with rsp_valid.

Source files
------------

// File: rtl/fc_cpu_bus_master_pkg.sv
// Shared types and constants for the FC cartridge CPU bus master and its phase counter.
package fc_bus_pkg;

   localparam int   FC_DIV        = 14;
   localparam int   FC_HOLD_CYC   = 1;
   localparam int   CPU_AW        = 15;
   localparam logic ROMSEL_ACTIVE = 1'b0;
   localparam logic RW_READ       = 1'b1;

   typedef enum logic [1:0] {IDLE, PHI1, PHI2, HOLD} bus_state_e;

   typedef logic [$clog2(FC_DIV)-1:0] phase_t;

   // /ROMSEL level for the M2-high half of a cycle, given the latched addr[15].
   function automatic logic romsel_level(input logic rom_sel);
      return rom_sel ? ROMSEL_ACTIVE : ~ROMSEL_ACTIVE;
   endfunction

endpackage

// File: rtl/fc_cpu_bus_master_if.sv
// Command stream and cartridge-edge signals of the FC CPU bus master; master = the bus initiator.
interface fc_cpu_bus_master_if;
   import fc_bus_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_rw;
   logic [15:0]       cmd_addr;
   logic [7:0]        cmd_wdata;
   logic              rsp_valid;
   logic [7:0]        rsp_rdata;
   logic              m2;
   logic              romsel;
   logic              cpu_rw;
   logic [CPU_AW-1:0] cpu_addr;
   logic [7:0]        cpu_data_out;
   logic              cpu_data_oe;
   logic [7:0]        cpu_data_in;

   modport master (
      input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cpu_data_in,
      output cmd_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
             cpu_data_out, cpu_data_oe
   );

   modport slave (
      output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cpu_data_in,
      input  cmd_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
             cpu_data_out, cpu_data_oe
   );

endinterface

// File: rtl/fc_cpu_bus_master_m2_phase_ctr.sv
// Phase counter: counts 0..last_i while running and pulses phase_done_o on the last count.
module fc_m2_phase_ctr
   import fc_bus_pkg::*;
(
   input  logic   osc50,
   input  logic   rst_n,
   input  logic   run_i,
   input  phase_t last_i,
   output logic   phase_done_o
);

   phase_t cnt_q, cnt_d;

   assign phase_done_o = run_i && (cnt_q == last_i);

   always_comb begin
      cnt_d = cnt_q + phase_t'(1);
      if (!run_i || phase_done_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge osc50 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fc_cpu_bus_master.sv
// FC cartridge CPU bus initiator: one command -> one M2 cycle (PHI1, PHI2, HOLD).
// Optional FC_BUS_IDLE_CLK_EN: M2 free-runs with dummy reads of $0000 while idle.
module fc_cpu_bus_master
   import fc_bus_pkg::*;
#(
   parameter int DIV      = FC_DIV,
   parameter int HOLD_CYC = FC_HOLD_CYC
)(
   input logic                 osc50,
   input logic                 rst_n,
   fc_cpu_bus_master_if.master bus
);

   bus_state_e        state_q, state_d;
   logic              m2_q, m2_d;
   logic              romsel_q, romsel_d;
   logic              rw_q, rw_d;
   logic              oe_q, oe_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [CPU_AW-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              rom_q, rom_d;
   logic              dummy_q, dummy_d;
   logic              accept;
   logic              phase_done;
   phase_t            phase_last;

   assign bus.cmd_ready    = rst_n && (state_q == IDLE);
   assign accept           = bus.cmd_valid && bus.cmd_ready;
   assign bus.m2           = m2_q;
   assign bus.romsel       = romsel_q;
   assign bus.cpu_rw       = rw_q;
   assign bus.cpu_addr     = addr_q;
   assign bus.cpu_data_out = wdata_q;
   assign bus.cpu_data_oe  = oe_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_rdata    = rdata_q;

   always_comb begin
      phase_last = phase_t'(DIV - 1);
      if (state_q == HOLD) begin
         phase_last = phase_t'(HOLD_CYC - 1);
      end
`ifdef FC_BUS_IDLE_CLK_EN
      // The IDLE cycle already served as the first M2-low cycle of a dummy.
      if (state_q == PHI1 && dummy_q) begin
         phase_last = phase_t'(DIV - 2);
      end
`endif
   end

   fc_m2_phase_ctr u_phase_ctr (
      .osc50        (osc50),
      .rst_n        (rst_n),
      .run_i        (state_q != IDLE),
      .last_i       (phase_last),
      .phase_done_o (phase_done)
   );

   always_comb begin
      state_d     = state_q;
      m2_d        = m2_q;
      romsel_d    = romsel_q;
      rw_d        = rw_q;
      oe_d        = oe_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rom_d       = rom_q;
      dummy_d     = dummy_q;
      rsp_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = PHI1;
               rw_d    = bus.cmd_rw;
               addr_d  = bus.cmd_addr[CPU_AW-1:0];
               wdata_d = bus.cmd_wdata;
               oe_d    = (bus.cmd_rw != RW_READ);
               rom_d   = bus.cmd_addr[15];
               dummy_d = 1'b0;
            end
`ifdef FC_BUS_IDLE_CLK_EN
            else begin
               state_d = PHI1;
               rw_d    = RW_READ;
               addr_d  = '0;
               oe_d    = 1'b0;
               rom_d   = 1'b0;
               dummy_d = 1'b1;
            end
`endif
         end
         PHI1: begin
            if (phase_done) begin
               state_d  = PHI2;
               m2_d     = 1'b1;
               romsel_d = romsel_level(rom_q);
            end
         end
         PHI2: begin
            if (phase_done) begin
               state_d = HOLD;
               m2_d    = 1'b0;
               if (rw_q == RW_READ && !dummy_q) begin
                  rdata_d = bus.cpu_data_in;
               end
            end
         end
         HOLD: begin
            // romsel stays active through HOLD so targets see it at M2 fall.
            if (phase_done) begin
               state_d     = IDLE;
               romsel_d    = ~ROMSEL_ACTIVE;
               oe_d        = 1'b0;
               rw_d        = RW_READ;
               rsp_valid_d = !dummy_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge osc50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         m2_q        <= 1'b0;
         romsel_q    <= ~ROMSEL_ACTIVE;
         rw_q        <= RW_READ;
         oe_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rom_q       <= 1'b0;
         dummy_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         m2_q        <= m2_d;
         romsel_q    <= romsel_d;
         rw_q        <= rw_d;
         oe_q        <= oe_d;
         rsp_valid_q <= rsp_valid_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rom_q       <= rom_d;
         dummy_q     <= dummy_d;
      end
   end

endmodule

// File: tb/tb_fc_cpu_bus_master.sv
// Directed bench for fc_cpu_bus_master (DIV=14, HOLD_CYC=1); FC_BUS_IDLE_CLK_EN adds the idle-clock scenario.
module tb_fc_cpu_bus_master;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fc_cpu_bus_master_if bus_if ();

   fc_cpu_bus_master #(.DIV(14), .HOLD_CYC(1)) dut (
      .osc50 (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // Waits (bounded) for cmd_ready, then lets the accepting edge pass; cycle 1 follows.
   task automatic wait_accept(input bit keep, output int waited);
      waited = 0;
      while (bus_if.cmd_ready !== 1'b1 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk);
      #1;
      if (!keep) bus_if.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus_if.cmd_valid = 1'b0; bus_if.cmd_rw = 1'b1;
      bus_if.cmd_addr = 16'h0000; bus_if.cmd_wdata = 8'h00; bus_if.cpu_data_in = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_if.m2, bus_if.romsel, bus_if.cpu_rw, bus_if.cpu_data_oe, bus_if.cmd_ready, bus_if.rsp_valid} !== 6'b011000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 011000 (m2,romsel,rw,oe,ready,rsp)",
                  {bus_if.m2, bus_if.romsel, bus_if.cpu_rw, bus_if.cpu_data_oe, bus_if.cmd_ready, bus_if.rsp_valid});
      end
      checks++;
      if ({bus_if.cpu_addr, bus_if.cpu_data_out, bus_if.rsp_rdata} !== 31'h0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h dout=%h rdata=%h expected all 0",
                  bus_if.cpu_addr, bus_if.cpu_data_out, bus_if.rsp_rdata);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus_if.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b expected 1", bus_if.cmd_ready);
      end
      $display("txn reset released, cmd_ready=%b", bus_if.cmd_ready);
   endtask

   task automatic test_write_rom();
      int w = 0, m2_hi = 0, first_hi = 0, rs_lo = 0, hold_rs = 1, bad_bus = 0, rsp_at = 0, rsp_cnt = 0;
      bus_if.cmd_valid = 1'b1; bus_if.cmd_rw = 1'b0;
      bus_if.cmd_addr = 16'h8000; bus_if.cmd_wdata = 8'h02;
      wait_accept(1'b0, w);
      checks++;
      if (w >= 64) begin errors++; $display("FAIL write_accept_timeout: waited %0d expected <64", w); end
      for (int n = 1; n <= 34; n++) begin
         @(negedge clk);
         if (bus_if.m2 === 1'b1) begin m2_hi++; if (first_hi == 0) first_hi = n; end
         if (bus_if.romsel === 1'b0) rs_lo++;
         if (n == 29) hold_rs = bus_if.romsel;
         if (n <= 29 && (bus_if.cpu_data_oe !== 1'b1 || bus_if.cpu_data_out !== 8'h02 ||
                         bus_if.cpu_rw !== 1'b0 || bus_if.cpu_addr !== 15'h0000)) bad_bus++;
         if (n >= 30 && (bus_if.cpu_data_oe !== 1'b0 || bus_if.cpu_rw !== 1'b1 || bus_if.romsel !== 1'b1)) bad_bus++;
         if (bus_if.rsp_valid === 1'b1) begin rsp_cnt++; rsp_at = n; end
      end
      checks++;
      if (m2_hi != 14) begin errors++; $display("FAIL write_m2_high: got %0d cycles expected 14", m2_hi); end
      checks++;
      if (first_hi != 15) begin errors++; $display("FAIL write_m2_rise: got cycle %0d expected 15", first_hi); end
      checks++;
      if (rs_lo != 15) begin errors++; $display("FAIL write_romsel_low: got %0d cycles expected 15", rs_lo); end
      checks++;
      if (hold_rs !== 1'b0) begin errors++; $display("FAIL write_romsel_hold: got %b expected 0", hold_rs); end
      checks++;
      if (bad_bus != 0) begin errors++; $display("FAIL write_bus_pins: got %0d bad cycles expected 0", bad_bus); end
      checks++;
      if (rsp_at != 30) begin errors++; $display("FAIL write_latency: got %0d expected 30", rsp_at); end
      checks++;
      if (rsp_cnt != 1) begin errors++; $display("FAIL write_rsp_count: got %0d expected 1", rsp_cnt); end
      $display("txn write $8000<=$02 rsp at cycle %0d", rsp_at);
   endtask

   task automatic test_read_ram();
      int w = 0, rs_lo = 0, oe_hi = 0, rw_bad = 0, addr_bad = 0, rsp_at = 0;
      logic [7:0] rd = 8'h00;
      bus_if.cpu_data_in = 8'hA5;
      bus_if.cmd_valid = 1'b1; bus_if.cmd_rw = 1'b1;
      bus_if.cmd_addr = 16'h6000; bus_if.cmd_wdata = 8'hEE;
      wait_accept(1'b0, w);
      for (int n = 1; n <= 32; n++) begin
         @(negedge clk);
         if (bus_if.romsel === 1'b0) rs_lo++;
         if (bus_if.cpu_data_oe === 1'b1) oe_hi++;
         if (bus_if.cpu_rw !== 1'b1) rw_bad++;
         if (n <= 30 && bus_if.cpu_addr !== 15'h6000) addr_bad++;
         if (bus_if.rsp_valid === 1'b1) begin rsp_at = n; rd = bus_if.rsp_rdata; end
      end
      checks++;
      if (rs_lo != 0) begin errors++; $display("FAIL ram_romsel: got %0d low cycles expected 0", rs_lo); end
      checks++;
      if (oe_hi != 0) begin errors++; $display("FAIL ram_oe: got %0d driven cycles expected 0", oe_hi); end
      checks++;
      if (rw_bad != 0) begin errors++; $display("FAIL ram_rw: got %0d write cycles expected 0", rw_bad); end
      checks++;
      if (addr_bad != 0) begin errors++; $display("FAIL ram_addr: got %0d wrong cycles expected 0", addr_bad); end
      checks++;
      if (rsp_at != 30) begin errors++; $display("FAIL ram_latency: got %0d expected 30", rsp_at); end
      checks++;
      if (rd !== 8'hA5) begin errors++; $display("FAIL ram_rdata: got %h expected a5", rd); end
      $display("txn read $6000 -> %h rsp at cycle %0d", rd, rsp_at);
   endtask

   task automatic test_read_hold();
      int w = 0, rs_lo = 0, rsp_at = 0;
      logic [7:0] rd = 8'h00;
      logic [14:0] mid_addr = '0;
      bus_if.cpu_data_in = 8'h11;
      bus_if.cmd_valid = 1'b1; bus_if.cmd_rw = 1'b1; bus_if.cmd_addr = 16'hFFFC;
      wait_accept(1'b0, w);
      for (int n = 1; n <= 32; n++) begin
         @(negedge clk);
         if (bus_if.romsel === 1'b0) rs_lo++;
         if (n == 20) mid_addr = bus_if.cpu_addr;
         if (n == 29) bus_if.cpu_data_in = 8'h22;
         if (bus_if.rsp_valid === 1'b1) begin rsp_at = n; rd = bus_if.rsp_rdata; end
      end
      checks++;
      if (rd !== 8'h11) begin errors++; $display("FAIL hold_rdata: got %h expected 11", rd); end
      checks++;
      if (rsp_at != 30) begin errors++; $display("FAIL hold_latency: got %0d expected 30", rsp_at); end
      checks++;
      if (rs_lo != 15) begin errors++; $display("FAIL hold_romsel_low: got %0d expected 15", rs_lo); end
      checks++;
      if (mid_addr !== 15'h7FFC) begin errors++; $display("FAIL hold_addr: got %h expected 7ffc", mid_addr); end
      checks++;
      if (bus_if.rsp_rdata !== 8'h11) begin errors++; $display("FAIL hold_rdata_kept: got %h expected 11", bus_if.rsp_rdata); end
      $display("txn read $FFFC -> %h rsp at cycle %0d", rd, rsp_at);
   endtask

   task automatic test_back_to_back();
      int w = 0, rises = 0, m2_hi = 0, rsp1 = 0, rsp2 = 0, bad1 = 0, bad2 = 0, contention = 0;
      logic prev_m2, ready30 = 1'b0, ready31 = 1'b1, rw31 = 1'b0;
      logic [14:0] addr31 = '0;
      logic [7:0] rd2 = 8'h00;
      bus_if.cpu_data_in = 8'h5A;
      bus_if.cmd_valid = 1'b1; bus_if.cmd_rw = 1'b0;
      bus_if.cmd_addr = 16'h8000; bus_if.cmd_wdata = 8'h77;
      wait_accept(1'b1, w);
      bus_if.cmd_rw = 1'b1; bus_if.cmd_addr = 16'h8001; bus_if.cmd_wdata = 8'hCC;
      prev_m2 = bus_if.m2;
      for (int n = 1; n <= 64; n++) begin
         @(negedge clk);
         if (prev_m2 === 1'b0 && bus_if.m2 === 1'b1) rises++;
         if (bus_if.m2 === 1'b1) m2_hi++;
         prev_m2 = bus_if.m2;
         if (bus_if.cpu_data_oe === 1'b1 && bus_if.cpu_rw === 1'b1) contention++;
         if (n <= 29 && (bus_if.cpu_addr !== 15'h0000 || bus_if.cpu_rw !== 1'b0 || bus_if.cpu_data_out !== 8'h77)) bad1++;
         if (n == 30) ready30 = bus_if.cmd_ready;
         if (n == 31) begin
            addr31 = bus_if.cpu_addr; rw31 = bus_if.cpu_rw; ready31 = bus_if.cmd_ready;
            bus_if.cmd_valid = 1'b0;
         end
         if (n >= 31 && n <= 59 && (bus_if.cpu_addr !== 15'h0001 || bus_if.cpu_rw !== 1'b1 || bus_if.cpu_data_oe !== 1'b0)) bad2++;
         if (bus_if.rsp_valid === 1'b1) begin
            if (rsp1 == 0) rsp1 = n; else begin rsp2 = n; rd2 = bus_if.rsp_rdata; end
         end
      end
      checks++;
      if (rsp1 != 30) begin errors++; $display("FAIL b2b_rsp1: got %0d expected 30", rsp1); end
      checks++;
      if (rsp2 != 60) begin errors++; $display("FAIL b2b_rsp2: got %0d expected 60", rsp2); end
      checks++;
      if (ready30 !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_rsp: got %b expected 1", ready30); end
      checks++;
      if ({ready31, rw31, addr31} !== {1'b0, 1'b1, 15'h0001}) begin
         errors++;
         $display("FAIL b2b_second_start: got ready=%b rw=%b addr=%h expected 0 1 0001", ready31, rw31, addr31);
      end
      checks++;
      if (rises != 2 || m2_hi != 28) begin
         errors++;
         $display("FAIL b2b_m2_pulses: got %0d rises %0d high expected 2 rises 28 high", rises, m2_hi);
      end
      checks++;
      if (bad1 != 0 || bad2 != 0) begin
         errors++;
         $display("FAIL b2b_latched_cmd: got %0d/%0d bad cycles expected 0/0", bad1, bad2);
      end
      checks++;
      if (contention != 0) begin errors++; $display("FAIL b2b_contention: got %0d cycles expected 0", contention); end
      checks++;
      if (rd2 !== 8'h5A) begin errors++; $display("FAIL b2b_rdata: got %h expected 5a", rd2); end
      $display("txn back-to-back write $8000 / read $8001 rsp at %0d and %0d", rsp1, rsp2);
   endtask

   task automatic test_reset_mid();
      int w = 0, rsp_cnt = 0, m2_hi = 0;
      logic m2_before = 1'b0;
      bus_if.cmd_valid = 1'b1; bus_if.cmd_rw = 1'b0;
      bus_if.cmd_addr = 16'h8000; bus_if.cmd_wdata = 8'h99;
      wait_accept(1'b0, w);
      repeat (20) @(negedge clk);
      m2_before = bus_if.m2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (m2_before !== 1'b1) begin errors++; $display("FAIL rstmid_in_phi2: got m2=%b expected 1", m2_before); end
      checks++;
      if ({bus_if.m2, bus_if.romsel, bus_if.cpu_rw, bus_if.cpu_data_oe, bus_if.rsp_valid, bus_if.cmd_ready} !== 6'b011000) begin
         errors++;
         $display("FAIL rstmid_outputs: got %b expected 011000 (m2,romsel,rw,oe,rsp,ready)",
                  {bus_if.m2, bus_if.romsel, bus_if.cpu_rw, bus_if.cpu_data_oe, bus_if.rsp_valid, bus_if.cmd_ready});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", bus_if.cmd_ready); end
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus_if.rsp_valid === 1'b1) rsp_cnt++;
         if (bus_if.m2 === 1'b1) m2_hi++;
      end
      checks++;
      if (rsp_cnt != 0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d pulses expected 0", rsp_cnt); end
`ifndef FC_BUS_IDLE_CLK_EN
      checks++;
      if (m2_hi != 0) begin errors++; $display("FAIL rstmid_m2_idle: got %0d high cycles expected 0", m2_hi); end
`endif
      $display("txn reset during PHI2 of write $8000, rsp pulses %0d", rsp_cnt);
   endtask

`ifdef FC_BUS_IDLE_CLK_EN
   task automatic test_idle_clk();
      int w = 0, rises = 0, last_rise = 0, bad_period = 0, rs_lo = 0, rsp_cnt = 0, oe_hi = 0, rsp_at = 0;
      logic prev_m2;
      logic [7:0] rd = 8'h00;
      prev_m2 = bus_if.m2;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (prev_m2 === 1'b0 && bus_if.m2 === 1'b1) begin
            if (last_rise != 0 && (n - last_rise) != 29) bad_period++;
            last_rise = n;
            rises++;
         end
         prev_m2 = bus_if.m2;
         if (bus_if.romsel === 1'b0) rs_lo++;
         if (bus_if.rsp_valid === 1'b1) rsp_cnt++;
         if (bus_if.cpu_data_oe === 1'b1) oe_hi++;
      end
      checks++;
      if (rises < 6 || bad_period != 0) begin
         errors++;
         $display("FAIL idle_m2_period: got %0d rises %0d off-period expected >=6 rises period 29", rises, bad_period);
      end
      checks++;
      if (rs_lo != 0 || rsp_cnt != 0 || oe_hi != 0) begin
         errors++;
         $display("FAIL idle_dummy_pins: got romsel_lo=%0d rsp=%0d oe=%0d expected 0 0 0", rs_lo, rsp_cnt, oe_hi);
      end
      bus_if.cpu_data_in = 8'h3C;
      bus_if.cmd_valid = 1'b1; bus_if.cmd_rw = 1'b1; bus_if.cmd_addr = 16'h8000;
      wait_accept(1'b0, w);
      checks++;
      if (w > 29) begin errors++; $display("FAIL idle_accept_wait: got %0d cycles expected <=29", w); end
      for (int n = 1; n <= 31; n++) begin
         @(negedge clk);
         if (bus_if.rsp_valid === 1'b1) begin rsp_at = n; rd = bus_if.rsp_rdata; end
      end
      checks++;
      if (rsp_at != 30 || rd !== 8'h3C) begin
         errors++;
         $display("FAIL idle_real_cycle: got rsp at %0d data %h expected 30 3c", rsp_at, rd);
      end
      $display("txn idle-clock read $8000 -> %h after waiting %0d cycles", rd, w);
   endtask
`else
   task automatic test_idle_quiet();
      int m2_hi = 0, not_ready = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (bus_if.m2 === 1'b1) m2_hi++;
         if (bus_if.cmd_ready !== 1'b1) not_ready++;
      end
      checks++;
      if (m2_hi != 0 || not_ready != 0) begin
         errors++;
         $display("FAIL idle_quiet: got m2_high=%0d not_ready=%0d expected 0 0", m2_hi, not_ready);
      end
      $display("txn idle 60 cycles, m2 high %0d", m2_hi);
   endtask
`endif

   initial begin
      test_reset();
      test_write_rom();
      test_read_ram();
      test_read_hold();
      test_back_to_back();
      test_reset_mid();
`ifdef FC_BUS_IDLE_CLK_EN
      test_idle_clk();
`else
      test_idle_quiet();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
